// File: rtl/dtr_pkg.sv
// Shared types and encodings for the DyTR redundancy checker path.
package dtr_pkg;

  typedef enum logic [1:0] {
    P0  = 2'd0,
    P1  = 2'd1,
    P2  = 2'd2,
    REC = 2'd3
  } state_t;

  localparam logic [1:0] CTR_P0 = 2'b00;
  localparam logic [1:0] CTR_P1 = 2'b01;
  localparam logic [1:0] CTR_P2 = 2'b10;

  localparam logic MODE_TTR = 1'b0;
  localparam logic MODE_DTR = 1'b1;

  // Phase counter value presented for a given state; recovery reads as phase 0.
  function automatic logic [1:0] ctrOf(input state_t s);
    logic [1:0] c;
    c = CTR_P0;
    case (s)
      P1:      c = CTR_P1;
      P2:      c = CTR_P2;
      default: c = CTR_P0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/voter3w.sv
// Bitwise 3-way majority with word-level agreement flags; purely combinational.
module voter3w #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj,
  output logic             any_pair_eq,
  output logic             all_eq
);

  assign maj         = (a & b) | (a & c) | (b & c);
  assign any_pair_eq = (a == b) || (a == c) || (b == c);
  assign all_eq      = (a == b) && (b == c);

endmodule

// File: rtl/dtr_vote_ctr.sv
// Time-redundancy checker: collects 2 (DTR) or 3 (TTR) copies of a word, emits the
// checked/voted word, flags uncorrectable disagreement and runs a fixed recovery.
module dtr_vote_ctr
  import dtr_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REC_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             modeS,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             fail,
  output logic             err_corr,
  output logic [1:0]       ctr,
  output logic             busy_rec
);

  localparam int unsigned CNT_W = $clog2(REC_LEN + 1);

  state_t             state, stateNext;
  logic [WIDTH-1:0]   s0, s0Next;
  logic [WIDTH-1:0]   s1, s1Next;
  logic               modeQ, modeQNext;
  logic [CNT_W-1:0]   recCnt, recCntNext;
  logic [WIDTH-1:0]   doutNext;
  logic               doutValidNext, failNext, errCorrNext;
  logic [1:0]         ctrNext;
  logic               busyRecNext;

  logic [WIDTH-1:0]   voteMaj;
  logic               voteAnyPair, voteAll;

  voter3w #(.WIDTH(WIDTH)) uVoter (
    .a          (s0),
    .b          (s1),
    .c          (din),
    .maj        (voteMaj),
    .any_pair_eq(voteAnyPair),
    .all_eq     (voteAll)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    stateNext     = state;
    s0Next        = s0;
    s1Next        = s1;
    modeQNext     = modeQ;
    recCntNext    = recCnt;
    doutNext      = dout;
    doutValidNext = 1'b0;
    failNext      = 1'b0;
    errCorrNext   = 1'b0;

    case (state)
      P0: begin
        if (din_valid) begin
          s0Next    = din;
          modeQNext = modeS;
          stateNext = P1;
        end
      end
      P1: begin
        if (din_valid) begin
          if (modeQ == MODE_DTR) begin
            if (din == s0) begin
              doutNext      = din;
              doutValidNext = 1'b1;
              stateNext     = P0;
            end else begin
              failNext   = 1'b1;
              recCntNext = CNT_W'(REC_LEN - 1);
              stateNext  = REC;
            end
          end else begin
            s1Next    = din;
            stateNext = P2;
          end
        end
      end
      P2: begin
        if (din_valid) begin
          if (voteAnyPair) begin
            doutNext      = voteMaj;
            doutValidNext = 1'b1;
            errCorrNext   = !voteAll;
            stateNext     = P0;
          end else begin
            failNext   = 1'b1;
            recCntNext = CNT_W'(REC_LEN - 1);
            stateNext  = REC;
          end
        end
      end
      REC: begin
        if (recCnt == CNT_W'(0)) begin
          stateNext = P0;
        end else begin
          recCntNext = recCnt - CNT_W'(1);
        end
      end
      default: stateNext = P0;
    endcase

    // Phase/recovery indicators track the state being entered so they register with it.
    ctrNext     = ctrOf(stateNext);
    busyRecNext = (stateNext == REC);
  end

  // State, sample and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= P0;
      s0         <= '0;
      s1         <= '0;
      modeQ      <= MODE_TTR;
      recCnt     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      fail       <= 1'b0;
      err_corr   <= 1'b0;
      ctr        <= CTR_P0;
      busy_rec   <= 1'b0;
    end else begin
      state      <= stateNext;
      s0         <= s0Next;
      s1         <= s1Next;
      modeQ      <= modeQNext;
      recCnt     <= recCntNext;
      dout       <= doutNext;
      dout_valid <= doutValidNext;
      fail       <= failNext;
      err_corr   <= errCorrNext;
      ctr        <= ctrNext;
      busy_rec   <= busyRecNext;
    end
  end

endmodule

// File: doc/dtr_vote_ctr.md
# dtr_vote_ctr

Upstream checker for the dynamic time-redundancy (DyTR) path. It samples each data word presented on 2 consecutive accepted beats (double, detect-only mode) or 3 (triple, vote-and-correct mode) and emits one voted word per item. It raises a one-cycle `fail` pulse that feeds the central control FSM's `fail` input, and drives the redundancy phase counter `ctr`. After an uncorrectable disagreement it runs a fixed recovery sequence that holds `ctr` at 00.

## Interface
- `WIDTH`, 8, data word width (≥1)
- `REC_LEN`, 4, recovery length in cycles (≥1, ≤255)
- `clk` in 1: global clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `modeS` in 1: redundancy mode from the control FSM; 0 = triple (TTR), 1 = double (DTR)
- `din` in WIDTH: redundant data copy for the current phase
- `din_valid` in 1: `din` is valid this cycle; phase advances only on accepted beats
- `dout` out WIDTH: voted/checked word
- `dout_valid` out 1: one-cycle strobe, `dout` holds a new item
- `fail` out 1: one-cycle pulse, uncorrectable disagreement detected
- `err_corr` out 1: one-cycle pulse, TTR disagreement masked by vote
- `ctr` out 2: current phase (00, 01, 10); forced 00 during recovery
- `busy_rec` out 1: high while in recovery

## Operation
- States: P0, P1, P2, REC. `ctr` encodes P0=00, P1=01, P2=10; REC drives 00.
- A beat is accepted when `din_valid`=1 in P0/P1/P2. `din_valid` is ignored in REC.
- P0 accept: latch `din` into s0, latch `modeS` into `mode_q`, go to P1. `modeS` is sampled only here; changes mid-item take effect on the next item.
- P1 accept, `mode_q`=1 (DTR):
  - `din`==s0: `dout`<=`din`, `dout_valid` pulse, go to P0.
  - `din`!=s0: `fail` pulse, no `dout_valid`, `dout` unchanged, go to REC.
- P1 accept, `mode_q`=0 (TTR): latch `din` into s1, go to P2.
- P2 accept (TTR only); let c = `din`:
  - Any two of s0, s1, c equal as words: `dout`<=bitwise majority(s0,s1,c), `dout_valid` pulse, go to P0.
  - In that case, if not all three are equal, also pulse `err_corr`.
  - All three pairwise different: `fail` pulse, no `dout_valid`, go to REC.
- REC: counter loaded with REC_LEN-1 on entry, decremented each cycle. Return to P0 when it reaches 0, so REC lasts exactly REC_LEN cycles. `busy_rec`=1 throughout.
- No `din_valid` in P0/P1/P2: hold state and samples indefinitely.
- `reset` has priority over every transition. Reset mid-item or mid-REC discards samples and returns to P0.

## Timing
- Reset values: state P0, `ctr`=00, `dout`=0, `dout_valid`=0, `fail`=0, `err_corr`=0, `busy_rec`=0, s0/s1=0, `mode_q`=0.
- All outputs are registered.
- `dout`/`dout_valid`/`fail`/`err_corr` appear in the cycle after the final-phase accept.
- `fail` and `dout_valid` are never high together.
- `ctr` and `busy_rec` reflect the state register. The first REC cycle is the same cycle `fail` is high.
- Throughput: TTR 1 item per 3 accepted beats; DTR 1 item per 2.
- No combinational path from `din` or `din_valid` to any output.
- `fail` feeds the control FSM register, which adds 1 more cycle before `userFail`.

## Structure
- Shared package `dtr_pkg`: state enum (P0, P1, P2, REC), phase encodings `CTR_P0`=2'b00, `CTR_P1`=2'b01, `CTR_P2`=2'b10, mode constants `MODE_TTR`=0, `MODE_DTR`=1.
- Sub-module `voter3w`: parameterized WIDTH-bit bitwise majority plus word-level `any_pair_eq` and `all_eq` flags; purely combinational.
- The REC counter is $clog2(REC_LEN+1) bits wide.

## Test plan
- TTR clean: `modeS`=0, beats 0x5A, 0x5A, 0x5A -> `dout`=0x5A and `dout_valid` 1 cycle after 3rd beat; `err_corr`=0, `fail`=0; `ctr` sequence 00, 01, 10, 00.
- TTR single upset: beats 0x5A, 0x5B, 0x5A -> `dout`=0x5A, `err_corr`=1, `fail`=0.
- TTR uncorrectable: beats 0x01, 0x02, 0x04 -> `fail`=1, no `dout_valid`. Then `busy_rec`=1 and `ctr`=00 for exactly 4 cycles; `din_valid` pulses during REC are ignored; the next beat lands in P0.
- DTR mismatch: `modeS`=1, beats 0x33, 0x37 -> `fail`=1, REC 4 cycles. With beats 0x33, 0x33 instead -> `dout`=0x33 and `ctr` sequence 00, 01, 00.
- Mode change mid-item: `modeS`=0 at P0 accept, `modeS`=1 before 2nd beat -> the item still completes in 3 beats; the next item uses 2 beats.
- Stall and reset: gaps of `din_valid`=0 between beats give the same results as the back-to-back cases. Asserting `reset` in P2, or in REC cycle 2, -> next cycle all outputs at reset values, `ctr`=00.
